// File: rtl/occupancy_ray_ctrl_if.sv
// Request/datapath bundle between the occupancy ray controller and its surroundings.
// The master modport is the controller; slave is the requester plus grid datapath.
interface occupancy_ray_ctrl_if #(
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 8
);
  logic              clear_req;
  logic              ray_valid;
  logic              ray_ready;
  logic [X_BITS-1:0] x0;
  logic [Y_BITS-1:0] y0;
  logic [X_BITS-1:0] x1;
  logic [Y_BITS-1:0] y1;
  logic              count_done;
  logic [X_BITS-1:0] cell_x;
  logic [Y_BITS-1:0] cell_y;
  logic              cell_is_free;
  logic              write_enable;
  logic              zero_cell;
  logic              reset_counter;
  logic              enable_counter;
  logic              busy;
  logic              ray_done;

  modport master (
    input  clear_req, ray_valid, x0, y0, x1, y1, count_done,
    output ray_ready, cell_x, cell_y, cell_is_free, write_enable, zero_cell,
           reset_counter, enable_counter, busy, ray_done
  );

  modport slave (
    output clear_req, ray_valid, x0, y0, x1, y1, count_done,
    input  ray_ready, cell_x, cell_y, cell_is_free, write_enable, zero_cell,
           reset_counter, enable_counter, busy, ray_done
  );
endinterface

// File: rtl/occupancy_ray_ctrl.sv
// Ray walker for the occupancy grid: Bresenham read-modify-write per cell, plus
// full-grid clear sequencing through the datapath sweep counter.
module occupancy_ray_ctrl #(
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  occupancy_ray_ctrl_if.master ctrl_if
);

  localparam int unsigned W = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;

  typedef enum logic [2:0] {
    StIdle, StClrInit, StClr, StLoad, StRd, StWr, StDone
  } state_e;

  state_e state_q, state_d;
  logic   clear_pending_q, clear_pending_d;

  logic [X_BITS-1:0] x0_q, x0_d, x1_q, x1_d, cx_q, cx_d, cell_x_q, cell_x_d;
  logic [Y_BITS-1:0] y0_q, y0_d, y1_q, y1_d, cy_q, cy_d, cell_y_q, cell_y_d;
  logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic signed [W-1:0] x0_s, x1_s, y0_s, y1_s, xdiff, ydiff, dx_abs, dy_neg;
  logic signed [W:0]   e2, dx_ext, dy_ext;
  logic                step_x, step_y, at_end, clr_pend;

  logic              ray_ready, cell_is_free, write_enable, zero_cell;
  logic              reset_counter, enable_counter, busy, ray_done;
  logic [X_BITS-1:0] cell_x;
  logic [Y_BITS-1:0] cell_y;

  assign x0_s   = W'(x0_q);
  assign x1_s   = W'(x1_q);
  assign y0_s   = W'(y0_q);
  assign y1_s   = W'(y1_q);
  assign xdiff  = x1_s - x0_s;
  assign ydiff  = y1_s - y0_s;
  assign dx_abs = xdiff[W-1] ? -xdiff : xdiff;
  assign dy_neg = ydiff[W-1] ? ydiff : -ydiff;

  assign e2     = {err_q, 1'b0};
  assign dx_ext = {dx_q[W-1], dx_q};
  assign dy_ext = {dy_q[W-1], dy_q};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign at_end = (cx_q == x1_q) && (cy_q == y1_q);

  // A clear request seen in IDLE on the same cycle as a ray still wins.
  assign clr_pend = clear_pending_q | ctrl_if.clear_req;

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q | ctrl_if.clear_req;
    x0_d = x0_q;  y0_d = y0_q;  x1_d = x1_q;  y1_d = y1_q;
    cx_d = cx_q;  cy_d = cy_q;
    dx_d = dx_q;  dy_d = dy_q;  err_d = err_q;
    sx_neg_d = sx_neg_q;  sy_neg_d = sy_neg_q;
    cell_x_d = (state_q == StRd) ? cx_q : cell_x_q;
    cell_y_d = (state_q == StRd) ? cy_q : cell_y_q;

    ray_ready      = 1'b0;
    cell_is_free   = 1'b0;
    write_enable   = 1'b0;
    zero_cell      = 1'b0;
    reset_counter  = 1'b0;
    enable_counter = 1'b0;
    busy           = 1'b0;
    ray_done       = 1'b0;
    cell_x         = cell_x_q;
    cell_y         = cell_y_q;

    unique case (state_q)
      StIdle: begin
        // Gated by reset_n so every output reads 0 while reset is held.
        ray_ready = reset_n & ~clr_pend;
        if (clr_pend) begin
          state_d = StClrInit;
        end else if (ctrl_if.ray_valid) begin
          x0_d    = ctrl_if.x0;
          y0_d    = ctrl_if.y0;
          x1_d    = ctrl_if.x1;
          y1_d    = ctrl_if.y1;
          state_d = StLoad;
        end
      end
      StClrInit: begin
        busy          = 1'b1;
        reset_counter = 1'b1;
        state_d       = StClr;
      end
      StClr: begin
        busy           = 1'b1;
        zero_cell      = 1'b1;
        write_enable   = 1'b1;
        enable_counter = 1'b1;
        if (ctrl_if.count_done) state_d = StIdle;
      end
      StLoad: begin
        busy     = 1'b1;
        cx_d     = x0_q;
        cy_d     = y0_q;
        dx_d     = dx_abs;
        dy_d     = dy_neg;
        err_d    = dx_abs + dy_neg;
        sx_neg_d = xdiff[W-1];
        sy_neg_d = ydiff[W-1];
        state_d  = StRd;
      end
      StRd: begin
        busy   = 1'b1;
        cell_x = cx_q;
        cell_y = cy_q;
        state_d = StWr;
      end
      StWr: begin
        busy         = 1'b1;
        cell_x       = cx_q;
        cell_y       = cy_q;
        write_enable = 1'b1;
        cell_is_free = ~at_end;
        if (at_end) begin
          state_d = StDone;
        end else begin
          err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          if (step_x) cx_d = sx_neg_q ? cx_q - X_BITS'(1) : cx_q + X_BITS'(1);
          if (step_y) cy_d = sy_neg_q ? cy_q - Y_BITS'(1) : cy_q + Y_BITS'(1);
          state_d = StRd;
        end
      end
      StDone: begin
        busy     = 1'b1;
        ray_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StClrInit) && (state_q != StClrInit)) clear_pending_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      clear_pending_q <= 1'b0;
      x0_q <= '0;  y0_q <= '0;  x1_q <= '0;  y1_q <= '0;
      cx_q <= '0;  cy_q <= '0;
      dx_q <= '0;  dy_q <= '0;  err_q <= '0;
      sx_neg_q <= 1'b0;  sy_neg_q <= 1'b0;
      cell_x_q <= '0;  cell_y_q <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      x0_q <= x0_d;  y0_q <= y0_d;  x1_q <= x1_d;  y1_q <= y1_d;
      cx_q <= cx_d;  cy_q <= cy_d;
      dx_q <= dx_d;  dy_q <= dy_d;  err_q <= err_d;
      sx_neg_q <= sx_neg_d;  sy_neg_q <= sy_neg_d;
      cell_x_q <= cell_x_d;  cell_y_q <= cell_y_d;
    end
  end

  assign ctrl_if.ray_ready      = ray_ready;
  assign ctrl_if.cell_x         = cell_x;
  assign ctrl_if.cell_y         = cell_y;
  assign ctrl_if.cell_is_free   = cell_is_free;
  assign ctrl_if.write_enable   = write_enable;
  assign ctrl_if.zero_cell      = zero_cell;
  assign ctrl_if.reset_counter  = reset_counter;
  assign ctrl_if.enable_counter = enable_counter;
  assign ctrl_if.busy           = busy;
  assign ctrl_if.ray_done       = ray_done;

endmodule

// File: doc/occupancy_ray_ctrl.md
Name: occupancy_ray_ctrl

Overview:
- Control stage directly upstream of the occupancy grid datapath.
- Accepts one laser ray at a time, given as a robot cell (x0,y0) and a hit cell (x1,y1).
- Walks the ray with integer Bresenham and issues one read-modify-write per cell: "free" on every cell except the endpoint, "occupied" on the endpoint.
- Also sequences full-grid clears using the datapath's zero_cell, counter and count_done signals.

Parameters:
- X_BITS, 8, width of x cell index (matches the grid width index type).
- Y_BITS, 8, width of y cell index (matches the grid height index type).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear_req  in  1  request to zero the whole grid; single-cycle pulse is sufficient.
- ray_valid  in  1  ray inputs are valid.
- ray_ready  out  1  controller can accept a ray.
- x0  in  X_BITS  ray start x (robot cell).
- y0  in  Y_BITS  ray start y.
- x1  in  X_BITS  ray end x (hit cell).
- y1  in  Y_BITS  ray end y.
- count_done  in  1  from datapath: clear sweep is at the last cell.
- cell_x  out  X_BITS  cell x index to datapath.
- cell_y  out  Y_BITS  cell y index to datapath.
- cell_is_free  out  1  1 = decrement cell, 0 = increment cell.
- write_enable  out  1  grid memory write strobe.
- zero_cell  out  1  datapath writes zero at its counter address.
- reset_counter  out  1  clears the datapath sweep counter.
- enable_counter  out  1  advances the datapath sweep counter.
- busy  out  1  controller is not idle.
- ray_done  out  1  one-cycle pulse when the endpoint write is issued.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE and the clear_pending flag is cleared.
  - All outputs are 0, including cell_x and cell_y.
  - Reset applied mid-ray or mid-clear abandons the operation with no further writes.
- clear_pending:
  - Set on any cycle with clear_req=1, in any state.
  - Cleared on entry to CLR_INIT.
- States: IDLE, CLR_INIT, CLR, LOAD, RD, WR, DONE.
- IDLE:
  - ray_ready = ~clear_pending; busy=0.
  - If clear_pending, go to CLR_INIT. Clear has priority over a simultaneous ray_valid, and that ray is not accepted.
  - Else if ray_valid: latch x0,y0,x1,y1 and go to LOAD.
- CLR_INIT: reset_counter=1 for one cycle, then go to CLR.
- CLR:
  - zero_cell=1, write_enable=1, enable_counter=1 every cycle.
  - When count_done=1 is sampled, that cycle's write still occurs, then go to IDLE.
- LOAD (one cycle):
  - dx=|x1-x0|, dy=-|y1-y0|, sx=(x1>=x0)?+1:-1, sy=(y1>=y0)?+1:-1.
  - err=dx+dy; current cell (cx,cy)=(x0,y0).
  - err, dx and dy are signed, max(X_BITS,Y_BITS)+2 bits. No overflow is possible; indices never leave the grid because every visited cell lies between the endpoints.
  - Go to RD.
- RD:
  - cell_x=cx, cell_y=cy, write_enable=0.
  - This cycle is the datapath's read latency.
- WR:
  - Same cell_x/cell_y; write_enable=1; cell_is_free = ((cx,cy) != (x1,y1)).
  - If the current cell is the endpoint, go to DONE.
  - Otherwise apply the Bresenham step and go to RD. Step: e2=2*err; if e2>=dy then err+=dy and cx+=sx; if e2<=dx then err+=dx and cy+=sy.
- DONE: ray_done=1 for one cycle, then go to IDLE.
- cell_x and cell_y hold their last value outside RD and WR. cell_is_free is 0 outside WR.
- Timing for a ray of N cells (N = max(|dx|,|dy|)+1):
  - Acceptance edge, then 1 LOAD + 2N (RD/WR) + 1 DONE cycle.
  - ray_ready returns high 2N+2 cycles after acceptance.
- Degenerate ray (start equals end): N=1, a single occupied increment.
- ray_valid while not ready is ignored. No ray is buffered.

Test Plan:
- Reset mid-operation: hold reset_n=0 during WR of a ray -> all outputs 0 immediately (asynchronously); after release the controller is idle with ray_ready=1 and no further write_enable.
- Ray (0,0)->(3,1): WR cycles hit (0,0),(1,0),(2,1) with cell_is_free=1, then (3,1) with cell_is_free=0; ray_done exactly 10 cycles after acceptance; ray_ready high on the next cycle.
- Ray (5,5)->(5,2): WR cells (5,5),(5,4),(5,3) free, (5,2) occupied; sy=-1 handled; exactly 4 write_enable pulses, each preceded by an RD cycle with the same address.
- Degenerate ray (7,7)->(7,7): one RD, one WR with cell_is_free=0, ray_done; 4 cycles total.
- clear_req pulsed during a ray: the ray completes normally, then one reset_counter cycle, then zero_cell/write_enable/enable_counter held until the bench asserts count_done after 10 cycles. Signals drop the following cycle. A simultaneous ray_valid is held off (ray_ready=0) until the clear ends.
- clear_req and ray_valid asserted together in IDLE: the clear runs first; the ray is accepted on the first cycle back in IDLE with ray_ready=1.
